// File: rtl/pid_pkg.sv
// Shared types and helpers for the heading PID loop stages.
// Heading angles wrap modulo 2^HDNG_W. The error is narrowed to ERR_W bits by saturation.
package pid_pkg;

  localparam int HDNG_W = 12;
  localparam int ERR_W  = 10;

  typedef logic signed [HDNG_W-1:0] hdng_t;
  typedef logic signed [ERR_W-1:0]  err_t;

  localparam hdng_t ERR_HI = hdng_t'((2 ** (ERR_W - 1)) - 1);
  localparam hdng_t ERR_LO = hdng_t'(-(2 ** (ERR_W - 1)));

  // Clamp a wrapped heading error into the signed ERR_W range.
  function automatic err_t sat_err(input hdng_t raw);
    if (raw > ERR_HI) begin
      sat_err = {1'b0, {(ERR_W - 1){1'b1}}};
    end else if (raw < ERR_LO) begin
      sat_err = {1'b1, {(ERR_W - 1){1'b0}}};
    end else begin
      sat_err = raw[ERR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hdng_settle_det.sv
// Settle detector: counts consecutive in-threshold error samples and
// raises at_hdng once SETTLE_CNT of them have arrived without interruption.
module hdng_settle_det
  import pid_pkg::*;
#(
  parameter int SETTLE_THRESH = 30,
  parameter int SETTLE_CNT    = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  moving,
  input  logic  v1,
  input  err_t  err_nxt,
  input  hdng_t dsrd_hdng,
  output logic  at_hdng
);

  localparam logic [3:0]     CNT_MAX = 4'(SETTLE_CNT);
  localparam logic [ERR_W:0] THRESH  = (ERR_W + 1)'(SETTLE_THRESH);

  logic [3:0]         cnt_q, cnt_d;
  hdng_t              dsrd_q;
  logic               at_hdng_q;
  logic signed [ERR_W:0] err_ext;
  logic [ERR_W:0]     mag;
  logic               in_thr;

  // One extra bit so that the most negative error (-512) has a representable magnitude.
  assign err_ext = {err_nxt[ERR_W-1], err_nxt};
  assign mag     = err_ext[ERR_W] ? (ERR_W + 1)'(-err_ext) : err_ext;
  assign in_thr  = (mag <= THRESH);

  // NOTE: cnt_d gets a default value first, so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!moving) begin
      cnt_d = '0;
    end else if (dsrd_hdng != dsrd_q) begin
      cnt_d = '0;
    end else if (v1 && in_thr) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
    end else if (v1) begin
      cnt_d = '0;
    end
  end

  // NOTE: non-blocking assignments here let every register sample the old state at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dsrd_q    <= '0;
      at_hdng_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dsrd_q    <= dsrd_hdng;
      at_hdng_q <= (cnt_d == CNT_MAX);
    end
  end

  assign at_hdng = at_hdng_q;

endmodule

// File: rtl/hdng_err.sv
// Heading error stage: a two-stage pipeline that first takes the wrapped difference and then saturates it.
// It also instantiates the settle detector that drives at_hdng.
module hdng_err
  import pid_pkg::*;
#(
  parameter int SETTLE_THRESH = 30,
  parameter int SETTLE_CNT    = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  moving,
  input  logic  hdng_vld,
  input  hdng_t heading,
  input  hdng_t dsrd_hdng,
  output err_t  err_sat,
  output logic  err_vld,
  output logic  at_hdng
);

  hdng_t err_raw_q;
  logic  v1_q;
  err_t  err_sat_q, err_nxt;
  logic  err_vld_q;

  // NOTE: err_raw_q carries data only and is always qualified by v1_q, so it does not need a reset.
  always_ff @(posedge clk) begin
    if (hdng_vld) begin
      err_raw_q <= heading - dsrd_hdng;
    end
  end

  assign err_nxt = sat_err(err_raw_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      err_sat_q <= '0;
      err_vld_q <= 1'b0;
    end else begin
      v1_q      <= hdng_vld;
      err_vld_q <= v1_q;
      if (v1_q) begin
        err_sat_q <= err_nxt;
      end
    end
  end

  hdng_settle_det #(
    .SETTLE_THRESH (SETTLE_THRESH),
    .SETTLE_CNT    (SETTLE_CNT)
  ) u_settle (
    .clk       (clk),
    .rst       (rst),
    .moving    (moving),
    .v1        (v1_q),
    .err_nxt   (err_nxt),
    .dsrd_hdng (dsrd_hdng),
    .at_hdng   (at_hdng)
  );

  assign err_sat = err_sat_q;
  assign err_vld = err_vld_q;

endmodule

// File: tb/tb_hdng_err.sv
// Scoreboard bench for hdng_err. Each driven sample pushes its expected error, at_hdng value and arrival cycle.
// A negedge monitor pops and compares them whenever err_vld is high.
module tb_hdng_err;

  logic       clk = 1'b0;
  logic       rst, moving, hdng_vld;
  logic [11:0] heading, dsrd_hdng;
  logic [9:0] err_sat;
  logic       err_vld, at_hdng;

  typedef struct {
    logic [9:0] err;
    logic       at;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   m_cnt  = 0;
  logic mon_en = 1'b0;

  hdng_err dut (
    .clk       (clk),
    .rst       (rst),
    .moving    (moving),
    .hdng_vld  (hdng_vld),
    .heading   (heading),
    .dsrd_hdng (dsrd_hdng),
    .err_sat   (err_sat),
    .err_vld   (err_vld),
    .at_hdng   (at_hdng)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive one sample on the next negedge. The expected result comes from plain integer arithmetic.
  task automatic send(input int h);
    int   d, mag;
    exp_t e;
    @(negedge clk);
    hdng_vld = 1'b1;
    heading  = 12'(h);
    d = (h - int'(dsrd_hdng)) & 32'hFFF;
    if (d >= 2048) d -= 4096;
    if (d > 511)   d = 511;
    if (d < -512)  d = -512;
    mag = (d < 0) ? -d : d;
    if (!moving)        m_cnt = 0;
    else if (mag <= 30) m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
    else                m_cnt = 0;
    e.err = 10'(d);
    e.at  = (m_cnt == 8);
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hdng_vld = 1'b0;
    end
  endtask

  task automatic send_spaced(input int h, input int n);
    repeat (n) begin
      send(h);
      idle(3);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && err_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_err_vld", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("err_sat", int'(err_sat), int'(e.err));
        check("at_hdng", int'(at_hdng), int'(e.at));
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; moving = 1'b0; hdng_vld = 1'b1;
    heading = 12'h100; dsrd_hdng = 12'h000;
    repeat (2) begin
      @(negedge clk);
      check("rst_err_sat", int'(err_sat), 0);
      check("rst_err_vld", int'(err_vld), 0);
      check("rst_at_hdng", int'(at_hdng), 0);
    end
    rst = 1'b0; hdng_vld = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_err_vld", int'(err_vld), 0);
      check("post_rst_err_sat", int'(err_sat), 0);
      check("post_rst_at_hdng", int'(at_hdng), 0);
    end
    mon_en = 1'b1;

    // Latency, single pulse and hold
    send(12'h100); idle(6);
    check("hold_err_sat", int'(err_sat), 10'h100);

    // Saturation edges
    send_spaced(12'h400, 1);
    send_spaced(12'hC00, 1);
    send_spaced(12'h1FF, 1);

    // Short-way-round wrap, back to back
    dsrd_hdng = 12'h810;
    for (int i = 0; i < 4; i++) send(12'h7F0);
    idle(4);

    // Settle: +20 error eight times, then a bad sample, then -30 eight times
    dsrd_hdng = 12'h000;
    moving = 1'b1;
    idle(2);
    m_cnt = 0;
    send_spaced(20, 8);
    send_spaced(-40, 1);
    send_spaced(-30, 8);

    // Moving dropped for one cycle
    check("pre_mov_at_hdng", int'(at_hdng), 1);
    @(negedge clk); moving = 1'b0;
    @(negedge clk); moving = 1'b1;
    check("mov_clr_at_hdng", int'(at_hdng), 0);
    m_cnt = 0;
    send_spaced(20, 8);

    // Commanded heading nudged by one
    check("pre_dsrd_at_hdng", int'(at_hdng), 1);
    @(negedge clk); dsrd_hdng = 12'h001;
    @(negedge clk);
    check("dsrd_clr_at_hdng", int'(at_hdng), 0);
    m_cnt = 0;
    send_spaced(21, 8);

    // Reset with a sample in flight: it must never emerge
    check("pre_rst_at_hdng", int'(at_hdng), 1);
    @(negedge clk); hdng_vld = 1'b1; heading = 12'h050;
    @(negedge clk); hdng_vld = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_at_hdng", int'(at_hdng), 0);
    check("mid_rst_err_sat", int'(err_sat), 0);
    m_cnt = 0;
    idle(6);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
